// File: rtl/dc_step_scheduler_pkg.sv
// dc_step_scheduler_pkg: shared types and defaults for the DC step scheduler.
// Holds the FSM state enum, default DEPTH/DWELL_W and the step-entry struct.
// The struct carries dwell at its widest supported size (MAX_DWELL_W); each
// instance stores and counts only DWELL_W bits of it.
package dc_step_scheduler_pkg;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_DWELL_W = 16;
    localparam int MAX_DWELL_W = 32;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    typedef struct packed {
        logic signed [15:0]     level;
        logic [MAX_DWELL_W-1:0] dwell;
    } step_t;
endpackage

// File: rtl/dc_step_scheduler_if.sv
// dc_step_scheduler_if: configuration, control and status bundle of the scheduler.
// master: table writes (cfg_*), sequence setup (last_idx, loop_en), control
//         (arm, trig, abort); reads level_out, step_idx, armed, busy, done, wr_err.
// slave:  the scheduler side of the same signals.
interface dc_step_scheduler_if
    import dc_step_scheduler_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DWELL_W = DEF_DWELL_W
);
    localparam int AW = $clog2(DEPTH);

    logic               cfg_wr;
    logic [AW-1:0]      cfg_addr;
    logic signed [15:0] cfg_level;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [AW-1:0]      last_idx;
    logic               loop_en;
    logic               arm;
    logic               trig;
    logic               abort;
    logic signed [15:0] level_out;
    logic [AW-1:0]      step_idx;
    logic               armed;
    logic               busy;
    logic               done;
    logic               wr_err;

    modport master (
        output cfg_wr, cfg_addr, cfg_level, cfg_dwell, last_idx, loop_en, arm, trig, abort,
        input  level_out, step_idx, armed, busy, done, wr_err
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_level, cfg_dwell, last_idx, loop_en, arm, trig, abort,
        output level_out, step_idx, armed, busy, done, wr_err
    );
endinterface

// File: rtl/dc_step_scheduler_table.sv
// dc_step_table: DEPTH x (16+DWELL_W) step register file.
// Ports: clk, reset (async, active low, clears every entry to {0,0}),
//        we/waddr/wdata one write port, raddr/rdata one asynchronous read port.
module dc_step_table
    import dc_step_scheduler_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  step_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output step_t                    rdata
);
    logic signed [15:0] lvl [DEPTH];
    logic [DWELL_W-1:0] dwl [DEPTH];
    logic               unused_wdata;

    // only DWELL_W dwell bits are stored; the struct's upper bits are zero padding
    assign unused_wdata = ^wdata.dwell;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvl[i] <= '0;
                dwl[i] <= '0;
            end
        end else if (we) begin
            lvl[waddr] <= wdata.level;
            dwl[waddr] <= wdata.dwell[DWELL_W-1:0];
        end
    end

    assign rdata = '{level: lvl[raddr], dwell: MAX_DWELL_W'(dwl[raddr])};
endmodule

// File: rtl/dc_step_scheduler.sv
// dc_step_scheduler: arm/trigger driven DC level sequencer over a step table.
// Ports: clk, reset (async, active low), s (dc_step_scheduler_if.slave):
//        table writes, last_idx/loop_en, arm/trig/abort in; registered
//        level_out, step_idx, armed/busy/done flags and wr_err pulse out.
module dc_step_scheduler
    import dc_step_scheduler_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input logic              clk,
    input logic              reset,
    dc_step_scheduler_if.slave s
);
    localparam int AW = $clog2(DEPTH);

    state_t             state, state_d;
    logic               trig_q, trig_vld, trig_edge;
    logic               load, expire;
    logic [AW-1:0]      idx_q, nxt_idx, last_q;
    logic               loop_q;
    logic [DWELL_W-1:0] rem;
    logic signed [15:0] level_q;
    logic               armed_q, busy_q, done_q, wr_err_q;
    step_t              wr_ent, rd_ent;
    logic               unused_rd;

    // trig_vld masks the first cycle after reset so a trig already high is not an edge
    assign trig_edge = s.trig & ~trig_q & trig_vld;
    // rem counts the cycles left on the current entry; dwell 0 and 1 both expire at once
    assign expire    = rem <= DWELL_W'(1);
    // the table is only ever read for the entry about to be loaded
    assign nxt_idx   = (state == RUN && idx_q != last_q) ? idx_q + AW'(1) : '0;
    assign wr_ent    = '{level: s.cfg_level, dwell: MAX_DWELL_W'(s.cfg_dwell)};
    assign unused_rd = ^rd_ent.dwell;

    dc_step_table #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (s.cfg_wr && state != RUN),
        .waddr (s.cfg_addr),
        .wdata (wr_ent),
        .raddr (nxt_idx),
        .rdata (rd_ent)
    );

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE, DONE: state_d = s.arm ? ARMED : state;
            ARMED: begin
                load    = trig_edge;
                state_d = trig_edge ? RUN : ARMED;
            end
            RUN: begin
                load    = expire && (idx_q != last_q || loop_q);
                state_d = (expire && !load) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
        if (s.abort) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            trig_q   <= 1'b0;
            trig_vld <= 1'b0;
            idx_q    <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            rem      <= '0;
            level_q  <= '0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state    <= state_d;
            trig_q   <= s.trig;
            trig_vld <= 1'b1;
            armed_q  <= state_d == ARMED;
            busy_q   <= state_d == RUN;
            done_q   <= state_d == DONE;
            wr_err_q <= s.cfg_wr && state == RUN;
            // tracking while ARMED leaves the trig-edge cycle's values frozen for the run
            if (state == ARMED) begin
                last_q <= s.last_idx;
                loop_q <= s.loop_en;
            end
            if (load) begin
                idx_q   <= nxt_idx;
                level_q <= rd_ent.level;
                rem     <= rd_ent.dwell[DWELL_W-1:0];
            end else if (state == RUN && !expire) begin
                rem <= rem - DWELL_W'(1);
            end
        end
    end

    assign s.level_out = level_q;
    assign s.step_idx  = idx_q;
    assign s.armed     = armed_q;
    assign s.busy      = busy_q;
    assign s.done      = done_q;
    assign s.wr_err    = wr_err_q;
endmodule
